// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and sizing helper for the radix-4 Booth multiplier
package booth_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} digit_e;

  // Operands are extended by two bits so the last digit also covers unsigned values.
  function automatic int n_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - parametrised parallel-prefix carry-lookahead adder with carry-in
module cla_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  // Only carries into bits 1..W-1 matter, so the prefix tree spans the low W-1 bits.
  localparam int M = W - 1;
  localparam int L = (M > 1) ? $clog2(M) : 0;

  logic [W-1:0] x;
  logic [M-1:0] g0, p0, g_all, p_all;
  logic [W-1:0] c;

  assign x  = a ^ b;
  assign g0 = a[M-1:0] & b[M-1:0];
  assign p0 = x[M-1:0];

  for (genvar l = 0; l < L; l++) begin : g_lvl
    logic [M-1:0] g_in, p_in, g_out, p_out;
    if (l == 0) begin : g_first
      assign g_in = g0;
      assign p_in = p0;
    end else begin : g_next
      assign g_in = g_lvl[l-1].g_out;
      assign p_in = g_lvl[l-1].p_out;
    end
    always_comb begin
      g_out = g_in;
      p_out = p_in;
      for (int i = (1 << l); i < M; i++) begin
        g_out[i] = g_in[i] | (p_in[i] & g_in[i-(1<<l)]);
        p_out[i] = p_in[i] & p_in[i-(1<<l)];
      end
    end
  end

  if (L == 0) begin : g_flat
    assign g_all = g0;
    assign p_all = p0;
  end else begin : g_tree
    assign g_all = g_lvl[L-1].g_out;
    assign p_all = g_lvl[L-1].p_out;
  end

  assign c   = {g_all | (p_all & {M{cin}}), cin};
  assign sum = x ^ c;

endmodule

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - sequential radix-4 Booth multiplier, one digit per cycle
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  localparam int N_ITER = n_iter(WIDTH);
  localparam int PW     = 2 * WIDTH;
  localparam int EW     = WIDTH + 2;
  localparam int CW     = $clog2(N_ITER);

  state_e        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [EW-1:0] mplier_q, mplier_d;
  logic          prev_q, prev_d;

  digit_e        digit;
  logic [PW-1:0] term, addend, sum;
  logic          neg;

  // Multiplicand is pre-shifted by two bits per digit, so the term is already at weight 4^i.
  always_comb begin
    digit = ZERO;
    case ({mplier_q[1:0], prev_q})
      3'b001, 3'b010: digit = P1;
      3'b011:         digit = P2;
      3'b100:         digit = M2;
      3'b101, 3'b110: digit = M1;
      default:        digit = ZERO;
    endcase
    term = '0;
    case (digit)
      P1, M1:  term = mcand_q;
      P2, M2:  term = {mcand_q[PW-2:0], 1'b0};
      default: term = '0;
    endcase
    neg    = (digit == M1) || (digit == M2);
    addend = neg ? ~term : term;
  end

  cla_adder #(.W(PW)) u_cla (
    .a   (acc_q),
    .b   (addend),
    .cin (neg),
    .sum (sum)
  );

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prev_d   = prev_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = CALC;
          iter_d   = '0;
          acc_d    = '0;
          mcand_d  = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
          mplier_d = {{2{in_signed & in_b[WIDTH-1]}}, in_b};
          prev_d   = 1'b0;
        end
      end
      CALC: begin
        acc_d    = sum;
        mcand_d  = {mcand_q[PW-3:0], 2'b00};
        mplier_d = {2'b00, mplier_q[EW-1:2]};
        prev_d   = mplier_q[1];
        if (iter_q == CW'(N_ITER - 1)) begin
          state_d = DONE;
        end else begin
          iter_d = iter_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      iter_q   <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prev_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prev_q   <= prev_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_product = acc_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb/tb_booth_seq_mult.sv - self-checking bench for booth_seq_mult
module tb_booth_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready, busy;
  logic [15:0] in_a, in_b;
  logic [31:0] out_product;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  booth_seq_mult #(.WIDTH(16)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [31:0] prod;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [31:0] exp, input bit hold, input string tag);
    int          lat;
    bit          ok;
    logic [31:0] prod;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(exp);
    chk({tag, "_busy"}, {busy, in_ready}, 2'b10);
    in_a = 16'($urandom); in_b = 16'($urandom); in_signed = 1'($urandom);
    out_ready = !hold;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      in_a = 16'($urandom); in_b = 16'($urandom);
      lat++;
    end
    chk({tag, "_latency"}, lat, 10);
    if (hold) begin
      prod = out_product;
      ok = 1'b1;
      repeat (5) begin
        @(posedge clk); #1;
        in_a = 16'($urandom); in_b = 16'($urandom);
        if (out_product !== prod || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
      end
      chk({tag, "_hold_stable"}, ok, 1'b1);
    end
    prod = out_product;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
    else chk(tag, prod, exp_q.pop_front());
    chk({tag, "_idle"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  // Parameter sweep: independent instances with random handshake gaps.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int W = (gi == 0) ? 4 : (gi == 1) ? 8 : 32;
    logic           s_rst, s_iv, s_ir, s_sg, s_ov, s_or, s_busy;
    logic [W-1:0]   s_a, s_b;
    logic [2*W-1:0] s_p;
    logic [2*W-1:0] sq[$];
    int             n_in, n_out;
    bit             fin = 1'b0;

    booth_seq_mult #(.WIDTH(W)) u_sw (
      .clk         (clk),
      .rst         (s_rst),
      .in_valid    (s_iv),
      .in_ready    (s_ir),
      .in_a        (s_a),
      .in_b        (s_b),
      .in_signed   (s_sg),
      .out_valid   (s_ov),
      .out_ready   (s_or),
      .out_product (s_p),
      .busy        (s_busy)
    );

    function automatic logic [2*W-1:0] ext(input logic [W-1:0] v, input logic sg);
      return sg ? {{W{v[W-1]}}, v} : {{W{1'b0}}, v};
    endfunction

    initial begin : drv
      logic [2*W-1:0] e;
      logic           rdy;
      int             t;
      s_rst = 1'b1; s_iv = 1'b0; s_a = '0; s_b = '0; s_sg = 1'b0; n_in = 0;
      repeat (2) @(posedge clk);
      #1 s_rst = 1'b0;
      for (int k = 0; k < 1000; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        s_a = W'($urandom); s_b = W'($urandom); s_sg = 1'($urandom);
        e = ext(s_a, s_sg) * ext(s_b, s_sg);
        s_iv = 1'b1;
        t = 0;
        do begin
          rdy = s_ir;
          @(posedge clk); #1;
          t++;
        end while (!rdy && t < 200);
        s_iv = 1'b0;
        if (rdy) begin
          sq.push_back(e);
          n_in++;
        end else begin
          chk($sformatf("sweep_w%0d_accept_timeout", W), 0, 1);
        end
      end
    end

    initial begin : mon
      int cyc;
      n_out = 0; s_or = 1'b0; cyc = 0;
      @(posedge clk); #1;
      while (n_out < 1000 && cyc < 60000) begin
        s_or = 1'($urandom);
        if (s_ov && s_or) begin
          if (sq.size() == 0) chk($sformatf("sweep_w%0d_sb_empty", W), 0, 1);
          else chk($sformatf("sweep_w%0d_prod", W), {s_busy, s_p}, {1'b1, sq.pop_front()});
          n_out++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      s_or = 1'b0;
      chk($sformatf("sweep_w%0d_out_count", W), n_out, 1000);
      chk($sformatf("sweep_w%0d_in_eq_out", W), n_in, n_out);
      fin = 1'b1;
    end
  end

  initial begin
    bit seen;
    vecs[0] = '{16'd3,    16'd2,    1'b1, 32'd6,         "s_3x2"};
    vecs[1] = '{16'hFFFD, 16'hFFFE, 1'b1, 32'd6,         "s_m3xm2"};
    vecs[2] = '{16'hFFFD, 16'd2,    1'b1, 32'hFFFFFFFA,  "s_m3x2"};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001,  "s_max_sq"};
    vecs[4] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000,  "s_min_sq"};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001,  "u_max_sq"};
    vecs[6] = '{16'h8000, 16'h0002, 1'b0, 32'h00010000,  "u_8000x2"};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'd1,         "s_m1xm1"};
    vecs[8] = '{16'h0000, 16'h1234, 1'b1, 32'd0,         "s_zero"};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("reset_state", {in_ready, out_valid, busy, out_product}, {3'b100, 32'd0});
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].prod, 1'b0, vecs[i].name);
    end

    do_op(16'h1234, 16'h5678, 1'b0, 32'h06260060, 1'b1, "backpressure");

    in_a = 16'h1234; in_b = 16'h0056; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_reset", {in_ready, out_valid, busy, out_product}, {3'b100, 32'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("no_valid_after_reset", seen, 1'b0);
    do_op(16'd5, 16'd7, 1'b0, 32'd35, 1'b0, "after_reset_5x7");

    for (int c = 0; c < 80000 && !(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin); c++) begin
      @(posedge clk);
    end
    chk("sweep_finished", {g_sw[0].fin, g_sw[1].fin, g_sw[2].fin}, 3'b111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
